// File: rtl/reservoir_sequencer.sv
// Sequencer for the hybrid DFR reservoir: fetches samples, applies the per-node mask,
// drives one reservoir update per virtual node and stores each result word.
module reservoir_sequencer #(
   parameter int NUM_VIRTUAL_NODES = 10,
   parameter int DATA_WIDTH        = 32,
   parameter int IN_ADDR_WIDTH     = 16,
   parameter int OUT_ADDR_WIDTH    = 20,
   parameter int TIMEOUT_CYCLES    = 65535
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic [IN_ADDR_WIDTH-1:0]      num_samples,
   input  logic [NUM_VIRTUAL_NODES-1:0]  mask,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic                          in_rd_en,
   output logic [IN_ADDR_WIDTH-1:0]      in_rd_addr,
   input  logic [DATA_WIDTH-1:0]         in_rd_data,
   output logic                          res_en,
   output logic [DATA_WIDTH-1:0]         res_din,
   input  logic [DATA_WIDTH-1:0]         res_dout,
   input  logic                          res_valid,
   output logic                          out_wr_en,
   output logic [OUT_ADDR_WIDTH-1:0]     out_wr_addr,
   output logic [DATA_WIDTH-1:0]         out_wr_data
);

   localparam int K_W = (NUM_VIRTUAL_NODES > 1) ? $clog2(NUM_VIRTUAL_NODES) : 1;
   localparam int T_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [K_W-1:0] K_LAST = K_W'(NUM_VIRTUAL_NODES - 1);
   localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CAPTURE, S_ARM, S_ISSUE, S_WAIT, S_STORE, S_FINISH
   } state_t;

   state_t                         state;
   logic [IN_ADDR_WIDTH-1:0]       num_q;
   logic [NUM_VIRTUAL_NODES-1:0]   mask_q;
   logic [DATA_WIDTH-1:0]          sample_q;
   logic [K_W-1:0]                 k_idx;
   logic [K_W-1:0]                 k_next;
   logic [IN_ADDR_WIDTH-1:0]       s_next;
   logic [T_W-1:0]                 tmo_cnt;
   logic                           abort_pend;

   function automatic logic [DATA_WIDTH-1:0] gate(input logic [DATA_WIDTH-1:0] d,
                                                  input logic sel);
      return sel ? d : '0;
   endfunction

   assign k_next = k_idx + K_W'(1);
   assign s_next = in_rd_addr + IN_ADDR_WIDTH'(1);

   // Strobes decode straight from the state register, so no input reaches an output.
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FINISH);
   assign in_rd_en  = (state == S_FETCH);
   assign res_en    = (state == S_ISSUE);
   assign out_wr_en = (state == S_STORE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         num_q       <= '0;
         mask_q      <= '0;
         sample_q    <= '0;
         k_idx       <= '0;
         tmo_cnt     <= '0;
         abort_pend  <= 1'b0;
         error       <= 1'b0;
         in_rd_addr  <= '0;
         res_din     <= '0;
         out_wr_addr <= '0;
         out_wr_data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  num_q       <= num_samples;
                  mask_q      <= mask;
                  error       <= 1'b0;
                  abort_pend  <= 1'b0;
                  in_rd_addr  <= '0;
                  k_idx       <= '0;
                  out_wr_addr <= '0;
                  state       <= (num_samples == '0) ? S_FINISH : S_FETCH;
               end
            end
            S_FETCH: state <= abort ? S_FINISH : S_CAPTURE;
            S_CAPTURE: begin
               sample_q <= in_rd_data;
               res_din  <= gate(in_rd_data, mask_q[k_idx]);
               state    <= abort ? S_FINISH : S_ARM;
            end
            S_ARM: begin
               if (abort)          state <= S_FINISH;
               else if (res_valid) state <= S_ISSUE;
            end
            S_ISSUE: begin
               tmo_cnt <= '0;
               if (abort) abort_pend <= 1'b1;
               state <= S_WAIT;
            end
            // An update in flight always completes; abort is deferred to STORE.
            S_WAIT: begin
               if (abort) abort_pend <= 1'b1;
               if (res_valid) begin
                  out_wr_data <= res_dout;
                  state       <= S_STORE;
               end else if (tmo_cnt == T_LAST) begin
                  error <= 1'b1;
                  state <= S_FINISH;
               end else begin
                  tmo_cnt <= tmo_cnt + T_W'(1);
               end
            end
            // Running write address equals s*N+k because nodes are visited in order.
            S_STORE: begin
               out_wr_addr <= out_wr_addr + OUT_ADDR_WIDTH'(1);
               if (abort || abort_pend) begin
                  state <= S_FINISH;
               end else if (k_idx != K_LAST) begin
                  k_idx   <= k_next;
                  res_din <= gate(sample_q, mask_q[k_next]);
                  state   <= S_ARM;
               end else begin
                  k_idx      <= '0;
                  in_rd_addr <= s_next;
                  state      <= (s_next == num_q) ? S_FINISH : S_FETCH;
               end
            end
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reservoir_sequencer.sv
// Bench for reservoir_sequencer: buffer and reservoir models, event monitor, and a
// reference that rebuilds the expected node/write stream from sample data and mask.
module tb_reservoir_sequencer;

   localparam int N   = 10;
   localparam int DW  = 32;
   localparam int IAW = 16;
   localparam int OAW = 20;
   localparam int TMO = 16;
   localparam logic [DW-1:0] XKEY = 32'hDEAD_BEEF;

   logic            clk = 1'b0;
   logic            rst_n, start, abort;
   logic [IAW-1:0]  num_samples;
   logic [N-1:0]    mask;
   logic            busy, done, error, in_rd_en, res_en, res_valid, out_wr_en;
   logic [IAW-1:0]  in_rd_addr;
   logic [DW-1:0]   in_rd_data, res_din, res_dout, out_wr_data;
   logic [OAW-1:0]  out_wr_addr;

   always #5 clk = ~clk;

   reservoir_sequencer #(
      .NUM_VIRTUAL_NODES(N), .DATA_WIDTH(DW), .IN_ADDR_WIDTH(IAW),
      .OUT_ADDR_WIDTH(OAW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .num_samples(num_samples), .mask(mask),
      .busy(busy), .done(done), .error(error),
      .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
      .res_en(res_en), .res_din(res_din), .res_dout(res_dout), .res_valid(res_valid),
      .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
   );

   // Input buffer: one-cycle read latency.
   logic [DW-1:0] in_mem [0:63];
   always @(posedge clk) if (in_rd_en) in_rd_data <= in_mem[in_rd_addr[5:0]];

   // Reservoir: busy for lat cycles after each update, result = din ^ XKEY; can hang.
   int            lat;
   bit            hang_mode;
   int            rb_cnt;
   bit            stuck;
   logic [DW-1:0] rdout_q;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rb_cnt  <= 0;
         stuck   <= 1'b0;
         rdout_q <= '0;
      end else begin
         if (res_en) begin
            rb_cnt  <= lat;
            rdout_q <= res_din ^ XKEY;
         end else if (rb_cnt > 0) begin
            rb_cnt <= rb_cnt - 1;
         end
         if (!hang_mode)  stuck <= 1'b0;
         else if (res_en) stuck <= 1'b1;
      end
   end
   assign res_valid = (rb_cnt == 0) && !stuck;
   assign res_dout  = res_valid ? rdout_q : ~rdout_q;

   // Monitor: logs every update request and write, counts cycles and rule violations.
   int            ncyc, n_en, n_wr, n_rd, n_done, busy_tot, unstable, en_bad;
   int            issue_cyc, done_cyc;
   logic          err_at_done;
   logic [DW-1:0] din_log [0:1023];
   logic [OAW-1:0] wa_log [0:1023];
   logic [DW-1:0] wd_log [0:1023];
   bit            hold;
   bit            prev_valid = 1'b1;
   logic [DW-1:0] hold_val;
   always @(negedge clk) begin
      ncyc       <= ncyc + 1;
      prev_valid <= res_valid;
      if (!rst_n) begin
         hold <= 1'b0;
      end else begin
         if (busy)     busy_tot <= busy_tot + 1;
         if (in_rd_en) n_rd <= n_rd + 1;
         if (res_en) begin
            din_log[n_en % 1024] <= res_din;
            n_en      <= n_en + 1;
            issue_cyc <= ncyc;
            hold      <= 1'b1;
            hold_val  <= res_din;
            if (!prev_valid) en_bad <= en_bad + 1;
         end else if (hold && res_din !== hold_val) begin
            unstable <= unstable + 1;
         end
         if (out_wr_en) begin
            wa_log[n_wr % 1024] <= out_wr_addr;
            wd_log[n_wr % 1024] <= out_wr_data;
            n_wr <= n_wr + 1;
            hold <= 1'b0;
         end
         if (done) begin
            n_done      <= n_done + 1;
            done_cyc    <= ncyc;
            err_at_done <= error;
            hold        <= 1'b0;
         end
      end
   end

   int n_cmp, n_bad;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_busy"},      64'(busy), 64'(0));
      chk({p, "_done"},      64'(done), 64'(0));
      chk({p, "_error"},     64'(error), 64'(0));
      chk({p, "_in_rd_en"},  64'(in_rd_en), 64'(0));
      chk({p, "_res_en"},    64'(res_en), 64'(0));
      chk({p, "_out_wr_en"}, 64'(out_wr_en), 64'(0));
      chk({p, "_rd_addr"},   64'(in_rd_addr), 64'(0));
      chk({p, "_res_din"},   64'(res_din), 64'(0));
      chk({p, "_wr_addr"},   64'(out_wr_addr), 64'(0));
      chk({p, "_wr_data"},   64'(out_wr_data), 64'(0));
   endtask

   task automatic wait_done(input int base, input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (n_done != base) seen = 1'b1;
         else step();
      end
   endtask

   // Full run against the reference: node stream s-major, k-minor, addr = s*N+k.
   task automatic run_case(input int S, input logic [N-1:0] m, input int L, input bit ign);
      int b_en, b_wr, b_rd, b_done, b_busy, b_uns, b_bad, idx;
      bit seen;
      logic [DW-1:0] d;
      b_en = n_en; b_wr = n_wr; b_rd = n_rd; b_done = n_done;
      b_busy = busy_tot; b_uns = unstable; b_bad = en_bad;
      lat = L; num_samples = IAW'(S); mask = m; start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_t1",   64'(busy), 64'(1));
      chk("rd_en_t1",  64'(in_rd_en), 64'(S > 0));
      chk("done_t1",   64'(done), 64'(S == 0));
      chk("error_clr", 64'(error), 64'(0));
      if (ign) begin
         repeat (4) step();
         num_samples = IAW'(S + 3); mask = ~m; start = 1'b1;
         step();
         start = 1'b0;
      end
      wait_done(b_done, 3000, seen);
      chk("done_seen", 64'(seen), 64'(1));
      step();
      chk("idle_after",  64'(busy), 64'(0));
      chk("done_count",  64'(n_done - b_done), 64'(1));
      chk("busy_cycles", 64'(busy_tot - b_busy), 64'(S * (2 + N * (L + 4)) + 1));
      chk("en_count",    64'(n_en - b_en), 64'(S * N));
      chk("wr_count",    64'(n_wr - b_wr), 64'(S * N));
      chk("rd_count",    64'(n_rd - b_rd), 64'(S));
      chk("error_end",   64'(error), 64'(0));
      chk("din_stable",  64'(unstable - b_uns), 64'(0));
      chk("en_ready",    64'(en_bad - b_bad), 64'(0));
      for (int s = 0; s < S; s++) begin
         for (int k = 0; k < N; k++) begin
            idx = s * N + k;
            d = m[k] ? in_mem[s] : '0;
            chk("din",     64'(din_log[(b_en + idx) % 1024]), 64'(d));
            chk("wr_addr", 64'(wa_log[(b_wr + idx) % 1024]), 64'(idx));
            chk("wr_data", 64'(wd_log[(b_wr + idx) % 1024]), 64'(d ^ XKEY));
         end
      end
   endtask

   initial begin
      int b_en, b_wr, b_done, rs, rl;
      bit seen;
      logic [N-1:0] rm;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_samples = '0; mask = '0;
      lat = 5; hang_mode = 1'b0;
      for (int i = 0; i < 64; i++) in_mem[i] = '0;
      repeat (3) step();
      chk_zero("reset");
      rst_n = 1'b1;
      step(); step();
      chk("idle_after_reset", 64'(busy), 64'(0));

      // Nominal run: S=3, all nodes enabled, L=5, input[s]=s+1.
      for (int s = 0; s < 3; s++) in_mem[s] = DW'(s + 1);
      run_case(3, 10'h3FF, 5, 1'b0);

      // Mask gating on a single sample.
      in_mem[0] = 32'h0000_1234;
      run_case(1, 10'h155, 3, 1'b0);

      // Zero samples.
      run_case(0, 10'h3FF, 5, 1'b0);

      // Timeout: reservoir never returns ready after the first update.
      in_mem[0] = 32'h0000_00A5; in_mem[1] = 32'h0000_005A;
      hang_mode = 1'b1; lat = 5;
      b_en = n_en; b_wr = n_wr; b_done = n_done;
      num_samples = 2; mask = '1; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(b_done, 300, seen);
      chk("tmo_done_seen",  64'(seen), 64'(1));
      chk("tmo_latency",    64'(done_cyc - issue_cyc), 64'(TMO + 1));
      chk("tmo_err_at_done", 64'(err_at_done), 64'(1));
      chk("tmo_en_count",   64'(n_en - b_en), 64'(1));
      chk("tmo_no_write",   64'(n_wr - b_wr), 64'(0));
      step();
      chk("tmo_error_held", 64'(error), 64'(1));
      chk("tmo_idle",       64'(busy), 64'(0));
      hang_mode = 1'b0;
      step();
      run_case(1, 10'h3FF, 2, 1'b0);

      // Abort in WAIT of sample 1, node 4: write 14 completes, nothing after.
      for (int s = 0; s < 3; s++) in_mem[s] = DW'(s + 1);
      lat = 5;
      b_en = n_en; b_wr = n_wr; b_done = n_done;
      num_samples = 3; mask = '1; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 2000 && (n_en - b_en) < 15; i++) step();
      chk("abt_reached", 64'(n_en - b_en), 64'(15));
      step(); step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      wait_done(b_done, 200, seen);
      chk("abt_done_seen", 64'(seen), 64'(1));
      chk("abt_error", 64'(err_at_done), 64'(0));
      repeat (5) step();
      chk("abt_en_count", 64'(n_en - b_en), 64'(15));
      chk("abt_wr_count", 64'(n_wr - b_wr), 64'(15));
      chk("abt_last_addr", 64'(wa_log[(b_wr + 14) % 1024]), 64'(14));
      chk("abt_last_data", 64'(wd_log[(b_wr + 14) % 1024]), 64'(in_mem[1] ^ XKEY));

      // Asynchronous reset in the middle of WAIT, then a clean run.
      in_mem[0] = 32'hC0DE_0001; in_mem[1] = 32'hC0DE_0002;
      lat = 4;
      b_en = n_en;
      num_samples = 2; mask = '1; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 2000 && (n_en - b_en) < 3; i++) step();
      step(); step();
      chk("pre_rst_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      step(); step();
      rst_n = 1'b1;
      step();
      run_case(2, 10'h2AF, 4, 1'b1);

      // Randomized runs, alternating with a start pulse while busy.
      for (int r = 0; r < 4; r++) begin
         rs = int'($urandom_range(1, 4));
         rm = N'($urandom);
         rl = int'($urandom_range(0, 6));
         for (int s = 0; s < rs; s++) in_mem[s] = $urandom;
         run_case(rs, rm, rl, r[0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
